// File: rtl/spu_ma_pkg.sv
// Shared definitions for the SPU MA exponentiation sequencer: one-hot state
// encoding and the default window width.
package spu_ma_pkg;

  localparam int WIN_DEF = 2;

  localparam int ST_IDLE  = 0;
  localparam int ST_RDE   = 1;
  localparam int ST_SQR   = 2;
  localparam int ST_WCHK  = 3;
  localparam int ST_MUL   = 4;
  localparam int ST_ESMAX = 5;

  typedef enum logic [5:0] {
    IDLE  = 6'(1 << ST_IDLE),
    RDE   = 6'(1 << ST_RDE),
    SQR   = 6'(1 << ST_SQR),
    WCHK  = 6'(1 << ST_WCHK),
    MUL   = 6'(1 << ST_MUL),
    ESMAX = 6'(1 << ST_ESMAX)
  } exp_state_e;

endpackage

// File: rtl/spu_maexp_sqcnt.sv
// Square counter for one exponent window: load-1 on the first square,
// increment on each further square, terminal count when WIN squares issued.
module spu_maexp_sqcnt
  import spu_ma_pkg::*;
#(
  parameter int WIN   = WIN_DEF,
  parameter int CNT_W = 2
) (
  input  logic rclk,
  input  logic reset,
  input  logic se,
  input  logic load,
  input  logic incr,
  output logic tc
);

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN);

  logic [CNT_W-1:0] sqcnt_d;
  logic [CNT_W-1:0] sqcnt_q;
  logic             unused_se;

  // Scan stitching is handled by the flop cells at implementation time.
  assign unused_se = se;

  always_comb begin
    sqcnt_d = sqcnt_q;
    if (load) begin
      sqcnt_d = CNT_W'(1);
    end else if (incr) begin
      sqcnt_d = sqcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      sqcnt_q <= '0;
    end else begin
      sqcnt_q <= sqcnt_d;
    end
  end

  assign tc = (sqcnt_q == WIN_C);

endmodule

// File: rtl/spu_maexp_win.sv
// Left-to-right fixed-window modular exponentiation sequencer: WIN squares per
// window, then one table multiply when the window value is nonzero.
module spu_maexp_win
  import spu_ma_pkg::*;
#(
  parameter int WIN   = WIN_DEF,
  parameter int CNT_W = 2
) (
  input  logic           rclk,
  input  logic           reset,
  input  logic           se,
  input  logic           spu_mactl_iss_pulse_dly,
  input  logic           spu_mactl_expop,
  input  logic           spu_mactl_kill_op,
  input  logic           spu_mactl_stxa_force_abort,
  input  logic           spu_mared_red_done,
  input  logic           spu_maaddr_esmax,
  input  logic           spu_maaddr_esmod64,
  input  logic [WIN-1:0] spu_madp_e_win,
  output logic           spu_maexp_e_rd_oprnd_sel,
  output logic           spu_maexp_memren,
  output logic           spu_maexp_e_data_wen,
  output logic           spu_maexp_shift_e,
  output logic           spu_maexp_incr_es_ptr,
  output logic           spu_maexp_es_max_init,
  output logic           spu_maexp_es_e_ptr_rst,
  output logic           spu_maexp_start_mulred_aequb,
  output logic           spu_maexp_start_mulred_anoteqb,
  output logic [WIN-1:0] spu_maexp_mul_idx,
  output logic           spu_maexp_busy,
  output logic           spu_maexp_done_set
);

  exp_state_e     state_d, state_q;
  logic [WIN-1:0] mul_idx_d, mul_idx_q;
  logic           busy_d, busy_q;
  logic           done_set_d, done_set_q;

  logic local_abort;
  logic exp_done;
  logic state_reset;
  logic expop_start;
  logic done_evt;
  logic sq_load;
  logic sq_incr;
  logic sq_tc;

  spu_maexp_sqcnt #(
    .WIN   (WIN),
    .CNT_W (CNT_W)
  ) u_sqcnt (
    .rclk  (rclk),
    .reset (reset),
    .se    (se),
    .load  (sq_load),
    .incr  (sq_incr),
    .tc    (sq_tc)
  );

  always_comb begin
    local_abort = spu_mared_red_done & spu_mactl_stxa_force_abort;
    exp_done    = state_q[ST_ESMAX] & spu_maaddr_esmax;
    state_reset = reset | exp_done | spu_mactl_kill_op | local_abort;
    expop_start = spu_mactl_iss_pulse_dly & spu_mactl_expop;

    state_d                        = state_q;
    mul_idx_d                      = mul_idx_q;
    sq_load                        = 1'b0;
    sq_incr                        = 1'b0;
    spu_maexp_e_rd_oprnd_sel       = 1'b0;
    spu_maexp_memren               = 1'b0;
    spu_maexp_incr_es_ptr          = 1'b0;
    spu_maexp_es_max_init          = 1'b0;
    spu_maexp_start_mulred_aequb   = 1'b0;
    spu_maexp_start_mulred_anoteqb = 1'b0;

    // A reset/kill/abort/finish overrides every transition and start pulse.
    if (state_reset) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (expop_start) begin
            state_d                  = RDE;
            spu_maexp_es_max_init    = 1'b1;
            spu_maexp_e_rd_oprnd_sel = 1'b1;
            spu_maexp_memren         = 1'b1;
          end
        end
        RDE: begin
          state_d                      = SQR;
          spu_maexp_start_mulred_aequb = 1'b1;
          sq_load                      = 1'b1;
        end
        SQR: begin
          if (spu_mared_red_done) begin
            if (sq_tc) begin
              state_d = WCHK;
            end else begin
              spu_maexp_start_mulred_aequb = 1'b1;
              sq_incr                      = 1'b1;
            end
          end
        end
        WCHK: begin
          if (|spu_madp_e_win) begin
            state_d                        = MUL;
            mul_idx_d                      = spu_madp_e_win;
            spu_maexp_start_mulred_anoteqb = 1'b1;
          end else begin
            state_d = ESMAX;
          end
        end
        MUL: begin
          if (spu_mared_red_done) begin
            state_d = ESMAX;
          end
        end
        ESMAX: begin
          // esmax=1 is handled as exp_done above; here another window follows.
          spu_maexp_incr_es_ptr = 1'b1;
          if (spu_maaddr_esmod64) begin
            state_d                  = RDE;
            spu_maexp_e_rd_oprnd_sel = 1'b1;
            spu_maexp_memren         = 1'b1;
          end else begin
            state_d                      = SQR;
            spu_maexp_start_mulred_aequb = 1'b1;
            sq_load                      = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    spu_maexp_e_data_wen   = state_q[ST_RDE] | state_q[ST_ESMAX];
    spu_maexp_shift_e      = state_q[ST_ESMAX];
    spu_maexp_es_e_ptr_rst = state_reset;

    busy_d   = (state_d != IDLE);
    done_evt = (exp_done | spu_mactl_kill_op | local_abort) & spu_mactl_expop;
    if (reset | spu_mactl_iss_pulse_dly) begin
      done_set_d = 1'b0;
    end else if (done_evt) begin
      done_set_d = 1'b1;
    end else begin
      done_set_d = done_set_q;
    end
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q    <= IDLE;
      mul_idx_q  <= '0;
      busy_q     <= 1'b0;
      done_set_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mul_idx_q  <= mul_idx_d;
      busy_q     <= busy_d;
      done_set_q <= done_set_d;
    end
  end

  assign spu_maexp_mul_idx  = mul_idx_q;
  assign spu_maexp_busy     = busy_q;
  assign spu_maexp_done_set = done_set_q;

endmodule

// File: tb/tb_spu_maexp_win.sv
// Directed bench for spu_maexp_win: a WIN=2 instance for the main sequences
// and a WIN=1 instance for the E-word reload path.
module tb_spu_maexp_win;

  logic       rclk;
  logic       reset, se, iss, expop, kill, abort, red_done, esmax, esmod64;
  logic [1:0] ewin2;
  logic       ewin1;

  logic       d_erd, d_memren, d_wen, d_shift, d_incr, d_esinit, d_ptrrst;
  logic       d_sq, d_mul, d_busy, d_done;
  logic [1:0] d_idx;
  logic       s_erd, s_memren, s_wen, s_shift, s_incr, s_esinit, s_ptrrst;
  logic       s_sq, s_mul, s_busy, s_done;
  logic       s_idx;

  int n_tests = 0;
  int n_fail  = 0;

  spu_maexp_win #(.WIN(2), .CNT_W(2)) dut2 (
    .rclk(rclk), .reset(reset), .se(se),
    .spu_mactl_iss_pulse_dly(iss), .spu_mactl_expop(expop),
    .spu_mactl_kill_op(kill), .spu_mactl_stxa_force_abort(abort),
    .spu_mared_red_done(red_done), .spu_maaddr_esmax(esmax),
    .spu_maaddr_esmod64(esmod64), .spu_madp_e_win(ewin2),
    .spu_maexp_e_rd_oprnd_sel(d_erd), .spu_maexp_memren(d_memren),
    .spu_maexp_e_data_wen(d_wen), .spu_maexp_shift_e(d_shift),
    .spu_maexp_incr_es_ptr(d_incr), .spu_maexp_es_max_init(d_esinit),
    .spu_maexp_es_e_ptr_rst(d_ptrrst), .spu_maexp_start_mulred_aequb(d_sq),
    .spu_maexp_start_mulred_anoteqb(d_mul), .spu_maexp_mul_idx(d_idx),
    .spu_maexp_busy(d_busy), .spu_maexp_done_set(d_done)
  );

  spu_maexp_win #(.WIN(1), .CNT_W(1)) dut1 (
    .rclk(rclk), .reset(reset), .se(se),
    .spu_mactl_iss_pulse_dly(iss), .spu_mactl_expop(expop),
    .spu_mactl_kill_op(kill), .spu_mactl_stxa_force_abort(abort),
    .spu_mared_red_done(red_done), .spu_maaddr_esmax(esmax),
    .spu_maaddr_esmod64(esmod64), .spu_madp_e_win(ewin1),
    .spu_maexp_e_rd_oprnd_sel(s_erd), .spu_maexp_memren(s_memren),
    .spu_maexp_e_data_wen(s_wen), .spu_maexp_shift_e(s_shift),
    .spu_maexp_incr_es_ptr(s_incr), .spu_maexp_es_max_init(s_esinit),
    .spu_maexp_es_e_ptr_rst(s_ptrrst), .spu_maexp_start_mulred_aequb(s_sq),
    .spu_maexp_start_mulred_anoteqb(s_mul), .spu_maexp_mul_idx(s_idx),
    .spu_maexp_busy(s_busy), .spu_maexp_done_set(s_done)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; iss = 1'b0; expop = 1'b0; kill = 1'b0; abort = 1'b0;
    red_done = 1'b0; esmax = 1'b0; esmod64 = 1'b0; ewin2 = 2'b00; ewin1 = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
  endtask

  // Launch an exponentiation on dut2; returns in the first SQR cycle.
  task automatic start2();
    iss = 1'b1; expop = 1'b1;
    #1;
    chk("idle_memren", 32'(d_memren), 1);
    chk("idle_erd", 32'(d_erd), 1);
    chk("idle_esinit", 32'(d_esinit), 1);
    chk("idle_sq", 32'(d_sq), 0);
    cyc();
    iss = 1'b0;
    #1;
    chk("rde_wen", 32'(d_wen), 1);
    chk("rde_shift", 32'(d_shift), 0);
    chk("rde_sq", 32'(d_sq), 1);
    chk("rde_busy", 32'(d_busy), 1);
    chk("rde_done", 32'(d_done), 0);
    cyc();
  endtask

  // One WIN=2 window on dut2 starting in SQR with one square outstanding.
  task automatic win2(input logic [1:0] w, input logic last);
    chk("sqr_noshift", 32'(d_shift), 0);
    red_done = 1'b1;
    #1;
    chk("sqr_sq2", 32'(d_sq), 1);
    cyc();
    #1;
    chk("sqr_tc_nosq", 32'(d_sq), 0);
    cyc();
    red_done = 1'b0; ewin2 = w;
    #1;
    chk("wchk_mul", 32'(d_mul), 32'(w != 2'b00));
    chk("wchk_sq", 32'(d_sq), 0);
    cyc();
    if (w != 2'b00) begin
      chk("mul_idx", 32'(d_idx), 32'(w));
      chk("mul_hold_nomul", 32'(d_mul), 0);
      red_done = 1'b1;
      #1;
      chk("mul_done_nosq", 32'(d_sq), 0);
      cyc();
      red_done = 1'b0;
    end
    esmax = last;
    #1;
    chk("esmax_shift", 32'(d_shift), 1);
    chk("esmax_wen", 32'(d_wen), 1);
    chk("esmax_sq", 32'(d_sq), 32'(!last));
    chk("esmax_ptrrst", 32'(d_ptrrst), 32'(last));
    chk("esmax_mul", 32'(d_mul), 0);
    cyc();
    esmax = 1'b0;
  endtask

  initial begin
    se = 1'b0;
    do_reset();
    chk("rst_busy", 32'(d_busy), 0);
    chk("rst_done", 32'(d_done), 0);
    chk("rst_idx", 32'(d_idx), 0);
    chk("rst_sq", 32'(d_sq), 0);
    chk("rst_memren", 32'(d_memren), 0);
    chk("rst_ptrrst", 32'(d_ptrrst), 0);
    chk("rst1_busy", 32'(s_busy), 0);

    // Windows 10 then 01: sq, sq, mul(2), sq, sq, mul(1), done.
    start2();
    #1;
    chk("sqr_hold_sq", 32'(d_sq), 0);
    iss = 1'b1;
    #1;
    chk("busy_start_ignored", 32'(d_memren), 0);
    cyc();
    iss = 1'b0;
    win2(2'b10, 1'b0);
    win2(2'b01, 1'b1);
    chk("t1_busy", 32'(d_busy), 0);
    chk("t1_done", 32'(d_done), 1);
    chk("t1_idle_sq", 32'(d_sq), 0);

    // Window value 00: no multiply, straight to ESMAX.
    start2();
    win2(2'b00, 1'b1);
    chk("t2_busy", 32'(d_busy), 0);
    chk("t2_done", 32'(d_done), 1);
    chk("t2_shift_once", 32'(d_shift), 0);

    // WIN=1 with an E-word reload after the second window.
    do_reset();
    iss = 1'b1; expop = 1'b1;
    #1;
    chk("w1_memren", 32'(s_memren), 1);
    cyc();
    iss = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("w1_rde_sq", 32'(s_sq), 1);
      cyc();
      red_done = 1'b1;
      #1;
      chk("w1_sqr_tc", 32'(s_sq), 0);
      cyc();
      red_done = 1'b0; ewin1 = 1'b1;
      #1;
      chk("w1_mul", 32'(s_mul), 1);
      cyc();
      chk("w1_idx", 32'(s_idx), 1);
      red_done = 1'b1;
      cyc();
      red_done = 1'b0; esmod64 = (k == 1);
      #1;
      chk("w1_incr", 32'(s_incr), 1);
      chk("w1_es_memren", 32'(s_memren), 32'(k == 1));
      chk("w1_es_erd", 32'(s_erd), 32'(k == 1));
      chk("w1_es_sq", 32'(s_sq), 32'(k != 1));
      chk("w1_es_shift", 32'(s_shift), 1);
      cyc();
      esmod64 = 1'b0;
      if (k == 0) begin
        // Back in SQR directly: model the square completing as RDE would.
        red_done = 1'b1;
        #1;
        chk("w1_sqr2_tc", 32'(s_sq), 0);
        cyc();
        red_done = 1'b0; ewin1 = 1'b0;
        #1;
        chk("w1_zero_nomul", 32'(s_mul), 0);
        cyc();
        #1;
        chk("w1_es0_incr", 32'(s_incr), 1);
        esmod64 = 1'b1;
        cyc();
        esmod64 = 1'b0;
      end
    end
    #1;
    chk("w1_rde_again_wen", 32'(s_wen), 1);
    chk("w1_rde_again_shift", 32'(s_shift), 0);
    chk("w1_rde_again_sq", 32'(s_sq), 1);
    chk("w1_rde_again_memren", 32'(s_memren), 0);

    // Kill coincident with red_done during MUL.
    do_reset();
    start2();
    red_done = 1'b1;
    cyc();
    cyc();
    red_done = 1'b0; ewin2 = 2'b11;
    cyc();
    chk("t4_idx", 32'(d_idx), 3);
    red_done = 1'b1; kill = 1'b1;
    #1;
    chk("t4_nosq", 32'(d_sq), 0);
    chk("t4_nomul", 32'(d_mul), 0);
    chk("t4_ptrrst", 32'(d_ptrrst), 1);
    cyc();
    red_done = 1'b0; kill = 1'b0;
    #1;
    chk("t4_busy", 32'(d_busy), 0);
    chk("t4_done", 32'(d_done), 1);
    chk("t4_idle_nosq", 32'(d_sq), 0);
    iss = 1'b1; expop = 1'b0;
    cyc();
    iss = 1'b0;
    chk("t4_done_clr", 32'(d_done), 0);
    chk("t4_nostart", 32'(d_busy), 0);

    // Abort (red_done & stxa_force_abort) in SQR.
    do_reset();
    start2();
    red_done = 1'b1; abort = 1'b1;
    #1;
    chk("t5_nosq", 32'(d_sq), 0);
    chk("t5_ptrrst", 32'(d_ptrrst), 1);
    cyc();
    red_done = 1'b0; abort = 1'b0;
    chk("t5_busy", 32'(d_busy), 0);
    chk("t5_done", 32'(d_done), 1);

    // Reset mid-SQR together with an issue pulse.
    do_reset();
    start2();
    reset = 1'b1; iss = 1'b1; expop = 1'b1;
    #1;
    chk("t6_ptrrst", 32'(d_ptrrst), 1);
    chk("t6_nomemren", 32'(d_memren), 0);
    chk("t6_nosq", 32'(d_sq), 0);
    cyc();
    reset = 1'b0; iss = 1'b0;
    #1;
    chk("t6_busy", 32'(d_busy), 0);
    chk("t6_done", 32'(d_done), 0);
    chk("t6_idx", 32'(d_idx), 0);
    chk("t6_memren", 32'(d_memren), 0);
    chk("t6_ptrrst_off", 32'(d_ptrrst), 0);
    cyc();
    chk("t6_no_rde_busy", 32'(d_busy), 0);
    chk("t6_no_rde_wen", 32'(d_wen), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
